// File: rtl/regdst_pkg.sv
// Shared types and constants for the destination-register tracker.
package regdst_pkg;

    localparam logic [3:0]  REGDST_MAX_WRITE = 4'd3;
    localparam int unsigned REGDST_AW        = 5;
    localparam int unsigned REGDST_TW        = 2;

    typedef struct packed {
        logic [REGDST_AW-1:0] a3;
        logic [REGDST_TW-1:0] tnew;
        logic                 cond;
    } track_entry_t;

endpackage

// File: rtl/regdst_hazard_port.sv
// Per-read-port hazard check: stall term and forward select over all tracked stages.
module regdst_hazard_port #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned AW     = 5,
    parameter int unsigned TW     = 2,
    parameter int unsigned FSW    = $clog2(STAGES + 1)
) (
    input  logic [AW-1:0]        addr_i,
    input  logic [TW-1:0]        tuse_i,
    input  logic [STAGES*AW-1:0] st_a3_i,
    input  logic [STAGES*TW-1:0] st_tnew_i,
    output logic                 stall_o,
    output logic [FSW-1:0]       fwd_o
);

    logic found;

    always_comb begin
        stall_o = 1'b0;
        fwd_o   = '0;
        found   = 1'b0;
        for (int k = 0; k < int'(STAGES); k++) begin
            logic          m;
            logic [TW-1:0] tn;
            m  = (addr_i != '0) && (st_a3_i[k*AW +: AW] == addr_i);
            tn = st_tnew_i[k*TW +: TW];
            if (m && (tn > tuse_i)) begin
                stall_o = 1'b1;
            end
            // Youngest match owns the forward decision; older stages are shadowed.
            if (m && !found) begin
                found = 1'b1;
                if (tn == '0) begin
                    fwd_o = FSW'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/regdst_track.sv
// Destination-register tracker: shifts {a3, tnew, cond} from E onward and drives stall/forwarding.
module regdst_track
    import regdst_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned AW     = REGDST_AW,
    parameter int unsigned TW     = REGDST_TW,
    parameter int unsigned FSW    = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 stall,
    input  logic [AW-1:0]        d_a3,
    input  logic [3:0]           d_regdst,
    input  logic [TW-1:0]        d_tnew,
    input  logic                 d_cond,
    input  logic                 e_cond_true,
    input  logic [AW-1:0]        rs_addr,
    input  logic [AW-1:0]        rt_addr,
    input  logic [TW-1:0]        rs_tuse,
    input  logic [TW-1:0]        rt_tuse,
    output logic [STAGES*AW-1:0] st_a3,
    output logic [STAGES*TW-1:0] st_tnew,
    output logic                 stall_req,
    output logic [FSW-1:0]       fwd_rs,
    output logic [FSW-1:0]       fwd_rt
);

    if (AW != REGDST_AW || TW != REGDST_TW) begin : g_width_check
        $error("regdst_track: AW/TW must match the regdst_pkg entry widths");
    end

    track_entry_t stage_q [STAGES];
    track_entry_t stage_d [STAGES];

    logic [AW-1:0] a3_in;
    logic          cond_in;
    logic          stall_rs;
    logic          stall_rt;

    assign a3_in   = (d_regdst <= REGDST_MAX_WRITE) ? d_a3 : '0;
    assign cond_in = d_cond & (a3_in != '0);

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            stage_d[k] = '0;
        end
        if (!stall) begin
            stage_d[0].a3   = a3_in;
            stage_d[0].tnew = d_tnew;
            stage_d[0].cond = cond_in;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            stage_d[k].a3   = stage_q[k-1].a3;
            stage_d[k].tnew = (stage_q[k-1].tnew == '0) ? '0 : stage_q[k-1].tnew - 1'b1;
            stage_d[k].cond = 1'b0;
        end
        // A conditional write that resolved false drops its destination on leaving E.
        if (stage_q[0].cond && !e_cond_true) begin
            stage_d[1].a3 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    always_comb begin
        st_a3   = '0;
        st_tnew = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            st_a3[k*AW +: AW]   = stage_q[k].a3;
            st_tnew[k*TW +: TW] = stage_q[k].tnew;
        end
    end

    regdst_hazard_port #(
        .STAGES (STAGES),
        .AW     (AW),
        .TW     (TW),
        .FSW    (FSW)
    ) u_port_rs (
        .addr_i    (rs_addr),
        .tuse_i    (rs_tuse),
        .st_a3_i   (st_a3),
        .st_tnew_i (st_tnew),
        .stall_o   (stall_rs),
        .fwd_o     (fwd_rs)
    );

    regdst_hazard_port #(
        .STAGES (STAGES),
        .AW     (AW),
        .TW     (TW),
        .FSW    (FSW)
    ) u_port_rt (
        .addr_i    (rt_addr),
        .tuse_i    (rt_tuse),
        .st_a3_i   (st_a3),
        .st_tnew_i (st_tnew),
        .stall_o   (stall_rt),
        .fwd_o     (fwd_rt)
    );

    assign stall_req = stall_rs | stall_rt;

endmodule

// File: tb/tb_regdst_track.sv
// Directed bench for regdst_track with STAGES=3, AW=5, TW=2.
module tb_regdst_track;

    logic        clk = 1'b0;
    logic        reset, flush, stall;
    logic [4:0]  d_a3;
    logic [3:0]  d_regdst;
    logic [1:0]  d_tnew;
    logic        d_cond, e_cond_true;
    logic [4:0]  rs_addr, rt_addr;
    logic [1:0]  rs_tuse, rt_tuse;
    logic [14:0] st_a3;
    logic [5:0]  st_tnew;
    logic        stall_req;
    logic [1:0]  fwd_rs, fwd_rt;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_a3;
    logic [5:0]  exp_tnew;

    always #5 clk = ~clk;

    regdst_track #(
        .STAGES (3),
        .AW     (5),
        .TW     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .stall       (stall),
        .d_a3        (d_a3),
        .d_regdst    (d_regdst),
        .d_tnew      (d_tnew),
        .d_cond      (d_cond),
        .e_cond_true (e_cond_true),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_tuse     (rs_tuse),
        .rt_tuse     (rt_tuse),
        .st_a3       (st_a3),
        .st_tnew     (st_tnew),
        .stall_req   (stall_req),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a3, input logic [3:0] rd, input logic [1:0] tn,
                         input logic cnd);
        d_a3 = a3; d_regdst = rd; d_tnew = tn; d_cond = cnd;
    endtask

    task automatic idle();
        d_a3 = 5'd0; d_regdst = 4'hF; d_tnew = 2'd0; d_cond = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (st_a3 !== 15'd0) begin errors++;
            $display("FAIL reset_a3: got %h expected 0", st_a3); end
        checks++; if (st_tnew !== 6'd0) begin errors++;
            $display("FAIL reset_tnew: got %h expected 0", st_tnew); end
        checks++; if (stall_req !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %b expected 0", stall_req); end
        checks++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin errors++;
            $display("FAIL reset_fwd: got rs=%0d rt=%0d expected 0/0", fwd_rs, fwd_rt); end
    endtask

    task automatic test_load_use();
        issue(5'd8, 4'd0, 2'd2, 1'b0);
        step();
        idle(); rs_addr = 5'd8; rs_tuse = 2'd0; stall = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++;
            $display("FAIL lu_stall_e: got %b expected 1", stall_req); end
        checks++; if (fwd_rs !== 2'd0) begin errors++;
            $display("FAIL lu_fwd_e: got %0d expected 0", fwd_rs); end
        step();
        checks++; if (st_tnew[3:2] !== 2'd1 || st_a3[9:5] !== 5'd8 || st_a3[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL lu_stage1: got a3=%h tnew=%h expected s1 a3=8 tnew=1, s0 bubble",
                     st_a3, st_tnew); end
        checks++; if (stall_req !== 1'b1) begin errors++;
            $display("FAIL lu_stall_m: got %b expected 1", stall_req); end
        step();
        checks++; if (st_tnew[5:4] !== 2'd0 || st_a3[14:10] !== 5'd8) begin errors++;
            $display("FAIL lu_stage2: got a3=%h tnew=%h expected s2 a3=8 tnew=0",
                     st_a3, st_tnew); end
        checks++; if (stall_req !== 1'b0 || fwd_rs !== 2'd3) begin errors++;
            $display("FAIL lu_fwd_w: got stall=%b fwd=%0d expected 0/3", stall_req, fwd_rs); end
        stall = 1'b0; rs_addr = 5'd0;
        step(); step(); step();
    endtask

    task automatic test_fwd_e();
        issue(5'd9, 4'd1, 2'd0, 1'b0);
        step();
        rt_addr = 5'd9; rt_tuse = 2'd0;
        issue(5'd9, 4'd1, 2'd1, 1'b0);
        #1;
        checks++; if (fwd_rt !== 2'd1 || stall_req !== 1'b0) begin errors++;
            $display("FAIL fwd_e: got fwd=%0d stall=%b expected 1/0", fwd_rt, stall_req); end
        step();
        idle();
        #1;
        // Younger E entry (tnew=1) shadows the ready M entry.
        checks++; if (fwd_rt !== 2'd0 || stall_req !== 1'b1) begin errors++;
            $display("FAIL fwd_shadow: got fwd=%0d stall=%b expected 0/1", fwd_rt, stall_req); end
        checks++; if (st_tnew[3:2] !== 2'd0) begin errors++;
            $display("FAIL tnew_sat: got %0d expected 0", st_tnew[3:2]); end
        rt_tuse = 2'd1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++;
            $display("FAIL tuse_equal: got %b expected 0", stall_req); end
        rt_addr = 5'd0; rt_tuse = 2'd0;
        step(); step(); step();
    endtask

    task automatic test_nowrite();
        issue(5'd5, 4'd4, 2'd0, 1'b0);
        step();
        idle(); rs_addr = 5'd5;
        #1;
        checks++; if (st_a3[4:0] !== 5'd0 || fwd_rs !== 2'd0) begin errors++;
            $display("FAIL nowrite: got a3=%0d fwd=%0d expected 0/0", st_a3[4:0], fwd_rs); end
        issue(5'd0, 4'd0, 2'd3, 1'b0);
        rs_addr = 5'd0;
        step();
        idle();
        #1;
        checks++; if (stall_req !== 1'b0 || fwd_rs !== 2'd0 || st_tnew[1:0] !== 2'd3) begin
            errors++;
            $display("FAIL reg0: got stall=%b fwd=%0d tnew=%0d expected 0/0/3",
                     stall_req, fwd_rs, st_tnew[1:0]); end
        issue(5'd7, 4'd3, 2'd0, 1'b0);
        step();
        idle();
        checks++; if (st_a3[4:0] !== 5'd7) begin errors++;
            $display("FAIL regdst3: got %0d expected 7", st_a3[4:0]); end
        step(); step(); step();
    endtask

    task automatic test_cond();
        issue(5'd10, 4'd0, 2'd1, 1'b1);
        step();
        idle(); e_cond_true = 1'b0; rs_addr = 5'd10; rs_tuse = 2'd0;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++;
            $display("FAIL cond_conservative: got %b expected 1", stall_req); end
        step();
        checks++; if (st_a3[9:5] !== 5'd0 || stall_req !== 1'b0) begin errors++;
            $display("FAIL cond_false: got a3=%0d stall=%b expected 0/0", st_a3[9:5], stall_req); end
        issue(5'd10, 4'd0, 2'd1, 1'b1);
        step();
        idle(); e_cond_true = 1'b1;
        step();
        checks++; if (st_a3[9:5] !== 5'd10 || fwd_rs !== 2'd2) begin errors++;
            $display("FAIL cond_true: got a3=%0d fwd=%0d expected 10/2", st_a3[9:5], fwd_rs); end
        issue(5'd11, 4'd0, 2'd1, 1'b0);
        step();
        idle(); e_cond_true = 1'b0;
        step();
        checks++; if (st_a3[9:5] !== 5'd11) begin errors++;
            $display("FAIL uncond_kept: got %0d expected 11", st_a3[9:5]); end
        rs_addr = 5'd0;
        step(); step(); step();
    endtask

    task automatic test_flush_stall();
        issue(5'd1, 4'd0, 2'd2, 1'b0); step();
        issue(5'd2, 4'd0, 2'd2, 1'b0); step();
        issue(5'd3, 4'd0, 2'd2, 1'b0); step();
        exp_a3 = {5'd1, 5'd2, 5'd3}; exp_tnew = {2'd0, 2'd1, 2'd2};
        checks++; if (st_a3 !== exp_a3 || st_tnew !== exp_tnew) begin errors++;
            $display("FAIL fill: got a3=%h tnew=%h expected %h/%h", st_a3, st_tnew, exp_a3,
                     exp_tnew); end
        issue(5'd4, 4'd0, 2'd2, 1'b0); stall = 1'b1;
        step();
        exp_a3 = {5'd2, 5'd3, 5'd0}; exp_tnew = {2'd0, 2'd1, 2'd0};
        checks++; if (st_a3 !== exp_a3 || st_tnew !== exp_tnew) begin errors++;
            $display("FAIL stall_bubble: got a3=%h tnew=%h expected %h/%h", st_a3, st_tnew,
                     exp_a3, exp_tnew); end
        stall = 1'b0; issue(5'd6, 4'd0, 2'd2, 1'b0);
        step();
        issue(5'd7, 4'd0, 2'd2, 1'b0); flush = 1'b1; stall = 1'b1;
        step();
        checks++; if (st_a3 !== 15'd0 || st_tnew !== 6'd0) begin errors++;
            $display("FAIL flush_stall: got a3=%h tnew=%h expected 0/0", st_a3, st_tnew); end
        flush = 1'b0; stall = 1'b0; issue(5'd12, 4'd2, 2'd3, 1'b0);
        step();
        checks++; if (st_a3[4:0] !== 5'd12 || st_tnew[1:0] !== 2'd3) begin errors++;
            $display("FAIL post_flush: got a3=%0d tnew=%0d expected 12/3", st_a3[4:0],
                     st_tnew[1:0]); end
        reset = 1'b1;
        step();
        checks++; if (st_a3 !== 15'd0 || st_tnew !== 6'd0) begin errors++;
            $display("FAIL mid_reset: got a3=%h tnew=%h expected 0/0", st_a3, st_tnew); end
        reset = 1'b0; idle();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0; e_cond_true = 1'b0;
        idle();
        rs_addr = 5'd0; rt_addr = 5'd0; rs_tuse = 2'd0; rt_tuse = 2'd0;
        test_reset();
        test_load_use();
        test_fwd_e();
        test_nowrite();
        test_cond();
        test_flush_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regdst_track.md
# regdst_track

Parametrised destination-register tracker for the pipelined MIPS core. It replaces the per-stage E/M/W destination muxes with one shift structure. Each entry holds a write-destination `a3` and a `tnew` countdown, carried through `STAGES` pipeline stages starting at E. The D stage sends the write-destination code of each issued instruction here. The block filters it by RegDst code and resolves conditional writes (slt-style ops decided in E). From the in-flight entries it produces the D-stage stall request and the forward selects.

## Interface
- `STAGES`, 3, tracked stages after D (0 = E, 1 = M, 2 = W); at least 2.
- `AW`, 5, register address width.
- `TW`, 2, width of `tnew` and `tuse`.
- `FSW`, `$clog2(STAGES+1)`, forward-select width.
- `clk`  in  1  the single clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high; clears every stage entry.
- `flush`  in  1  exception or eret flush; clears every stage on the next edge.
- `stall`  in  1  D-stage stall; E receives a bubble and the later stages keep advancing.
- `d_a3`  in  AW  candidate destination from the D decode.
- `d_regdst`  in  4  RegDst code; codes 0–3 write, every other code means no write.
- `d_tnew`  in  TW  cycles until the result exists, counted from E entry.
- `d_cond`  in  1  the write is conditional and is resolved in E.
- `e_cond_true`  in  1  condition outcome for the instruction now in E; valid only while E holds a conditional entry.
- `rs_addr`, `rt_addr`  in  AW  D-stage source registers.
- `rs_tuse`, `rt_tuse`  in  TW  cycles until each source is consumed.
- `st_a3`  out  STAGES*AW  packed per-stage destination; stage k occupies bits [k*AW +: AW].
- `st_tnew`  out  STAGES*TW  packed per-stage `tnew`.
- `stall_req`  out  1  D must stall this cycle.
- `fwd_rs`, `fwd_rt`  out  FSW  0 = read the register file; k+1 = forward from stage k.

## Operation
- **Entry formation.** `a3_in = (d_regdst <= 3) ? d_a3 : 0`. `cond_in = d_cond & (a3_in != 0)`.
- **Stage 0 update, per edge, in priority order:**
  - reset or flush: clear.
  - stall: load a bubble (`a3 = 0`, `tnew = 0`, `cond = 0`).
  - otherwise: load `{a3_in, d_tnew, cond_in}`.
- **Stage k ≥ 1 update, per edge:**
  - reset or flush: clear.
  - otherwise: load stage k-1 with `tnew` decremented, saturating at 0.
  - Stall does not freeze stages k ≥ 1.
- **Conditional resolve.** When stage 0 moves into stage 1:
  - if stage 0 `cond = 1` and `e_cond_true = 0`, the stage 1 `a3` loads 0.
  - stage 1 `cond` is always 0.
- **Conservative while unresolved.** While a conditional entry sits in stage 0, it counts as a write to its `a3` for stalling and forwarding.
- **Hazard, per port p in {rs, rt}:**
  - match(k) = `addr_p != 0` and `st_a3[k] == addr_p`.
  - `stall_req` = OR over ports and stages of (match(k) and `tnew[k] > tuse_p`).
- **Forward select.**
  - Take the lowest k with match(k).
  - `fwd_p = k+1` if `tnew[k] == 0`, otherwise 0.
  - An older stage never forwards past a younger matching entry.
  - Register 0 never forwards and never stalls.

## Timing
- Reset values: all `st_a3` = 0, all `st_tnew` = 0, all `cond` = 0. Therefore `stall_req` = 0 and `fwd_rs` = `fwd_rt` = 0.
- Latency:
  - An instruction accepted by D at edge n appears in stage 0 after edge n.
  - It appears in stage k after edge n+k.
- `stall_req` and `fwd_*` are combinational from the current stage registers and the D inputs, with no registered delay. `e_cond_true` affects only the next-edge state.
- Flush asserted together with stall: flush wins.
- Reset mid-operation clears all state in one edge. There is no drain.
- `tnew` that is 0 stays 0 and never wraps.

## Structure
- Shared package `regdst_pkg`:
  - `REGDST_MAX_WRITE = 4'd3`.
  - Default `AW` and `TW`.
  - Typedef `track_entry_t {a3, tnew, cond}`.
- One sub-module, `regdst_hazard_port`. It is combinational per read port (match, stall term, forward select) and is instantiated twice.
- The stage registers live in the top module as an array of `track_entry_t`.

## Test plan
- **Reset:** hold `reset` for 2 cycles, then release → all `st_a3` = 0, `stall_req` = 0, `fwd_rs` = 0.
- **Load-use stall:** issue `d_a3 = 8`, `d_regdst = 0`, `d_tnew = 2`. Next cycle `rs_addr = 8`, `rs_tuse = 0` → `stall_req = 1`. Hold stall one edge → stage 1 `tnew = 1`, still stalling. After the next edge → stage 2 `tnew = 0`, `stall_req = 0`, `fwd_rs = 3`.
- **Forward from E:** issue `d_a3 = 9`, `d_regdst = 1`, `d_tnew = 0`. Next cycle `rt_addr = 9` → `fwd_rt = 1`, `stall_req = 0`.
- **Non-writing code and register 0:**
  - `d_regdst = 4` with `d_a3 = 5` → stage 0 `a3 = 0`.
  - A source on register 0 never forwards (`fwd_rs = 0`).
- **Conditional write:**
  - Issue `d_a3 = 10`, `d_cond = 1`, `d_tnew = 1`, then drive `e_cond_true = 0` → stage 1 `a3 = 0`.
  - Repeat with `e_cond_true = 1` → stage 1 `a3 = 10`.
- **Flush versus stall:**
  - Fill all stages, then assert `flush` and `stall` together → all stages 0 after one edge.
  - Stall alone → stage 0 = bubble while stage 1 takes the old stage 0.
